// File: rtl/rgb_pwm_driver_if.sv
// Colour sample stream from the HSL-to-RGB stage into the PWM driver.
// Transfer rule: rgb_valid has no ready partner; every cycle in which
// rgb_valid is high carries one r/g/b sample and the consumer always takes it.
interface rgb_pwm_driver_if #(
    parameter int WIDTH = 8
);
    logic             rgb_valid;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;

    modport master (output rgb_valid, r, g, b);
    modport slave  (input  rgb_valid, r, g, b);
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver. Incoming samples are parked in a shadow
// register and only promoted to the active duty at a period boundary, so a
// running period is never cut short or stretched by a mid-period update.
// Samples overwritten in the shadow before being applied are counted.
module rgb_pwm_driver #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    rgb_pwm_driver_if.slave rgb,
    output logic            pwm_r,
    output logic            pwm_g,
    output logic            pwm_b,
    output logic            period_start,
    output logic [7:0]      drop_count
);
    // psc needs at least one bit even when PRESCALE is 1 (it then stays 0).
    localparam int               PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             wrap;

    logic             pending;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_g;
    logic [WIDTH-1:0] shadow_b;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] active_g;
    logic [WIDTH-1:0] active_b;

    assign tick = (psc == PSC_MAX);
    assign wrap = tick && (cnt == {WIDTH{1'b1}});

    // Prescaler and phase counter; cnt wraps naturally at 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc <= '0;
            cnt <= '0;
        end else begin
            psc <= tick ? '0 : psc + PSC_W'(1);
            if (tick) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

    // Shadow capture; a sample arriving on the wrap edge stays pending for the next period.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= '0;
            shadow_g <= '0;
            shadow_b <= '0;
            pending  <= 1'b0;
        end else if (rgb.rgb_valid) begin
            shadow_r <= rgb.r;
            shadow_g <= rgb.g;
            shadow_b <= rgb.b;
            pending  <= 1'b1;
        end else if (wrap) begin
            pending  <= 1'b0;
        end
    end

    // Promote the pre-edge shadow at the period boundary and flag the new period.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r     <= '0;
            active_g     <= '0;
            active_b     <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (wrap && pending) begin
                active_r <= shadow_r;
                active_g <= shadow_g;
                active_b <= shadow_b;
            end
        end
    end

    // Count overwrites of an unapplied sample; the wrap edge consumes the old one, so no drop there.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= 8'd0;
        end else if (rgb.rgb_valid && pending && !wrap && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // Registered PWM compare; duty 0 never fires, full-scale misses one step.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_r <= ACTIVE_LOW;
            pwm_g <= ACTIVE_LOW;
            pwm_b <= ACTIVE_LOW;
        end else begin
            pwm_r <= (cnt < active_r) ^ ACTIVE_LOW;
            pwm_g <= (cnt < active_g) ^ ACTIVE_LOW;
            pwm_b <= (cnt < active_b) ^ ACTIVE_LOW;
        end
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (PRESCALE=1/active-high and
// PRESCALE=4/active-low) fed the same sample stream, an arithmetic model of
// period position and sample bookkeeping, and directed literal checks.
module tb_rgb_pwm_driver;
    localparam int W     = 8;
    localparam int NSTEP = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v   = 1'b0;
    logic [W-1:0] rr  = '0;
    logic [W-1:0] gg  = '0;
    logic [W-1:0] bb  = '0;

    always #5 clk = ~clk;

    rgb_pwm_driver_if #(.WIDTH(W)) if0 ();
    rgb_pwm_driver_if #(.WIDTH(W)) if1 ();
    assign if0.rgb_valid = v;
    assign if0.r = rr;
    assign if0.g = gg;
    assign if0.b = bb;
    assign if1.rgb_valid = v;
    assign if1.r = rr;
    assign if1.g = gg;
    assign if1.b = bb;

    logic       pwm_r0, pwm_g0, pwm_b0, ps0;
    logic       pwm_r1, pwm_g1, pwm_b1, ps1;
    logic [7:0] drop0, drop1;

    rgb_pwm_driver #(.WIDTH(W), .PRESCALE(1), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .rgb(if0),
        .pwm_r(pwm_r0), .pwm_g(pwm_g0), .pwm_b(pwm_b0),
        .period_start(ps0), .drop_count(drop0)
    );

    rgb_pwm_driver #(.WIDTH(W), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .rgb(if1),
        .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1),
        .period_start(ps1), .drop_count(drop1)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    // k = clock edges since reset release. Position in the period is plain
    // arithmetic on k; the sample bookkeeping is "latest unapplied sample".
    int psc_of [2] = '{1, 4};
    bit al_of  [2] = '{1'b0, 1'b1};
    int k      = 0;
    bit m_init = 1'b0;
    bit m_pend [2];
    int m_sh   [2][3];
    int m_act  [2][3];
    int m_drop [2];
    int e_pwm  [2][3];
    int e_ps   [2];
    int m_in   [3];
    int phase;
    bit bnd;
    bit old_p;

    always @(posedge clk) begin
        if (rst) begin
            k      = 0;
            m_init = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 1'b0;
                m_drop[i] = 0;
                e_ps[i]   = 0;
                for (int c = 0; c < 3; c++) begin
                    m_sh[i][c]  = 0;
                    m_act[i][c] = 0;
                    e_pwm[i][c] = int'(al_of[i]);
                end
            end
        end else begin
            m_in[0] = int'(rr);
            m_in[1] = int'(gg);
            m_in[2] = int'(bb);
            for (int i = 0; i < 2; i++) begin
                phase = (k / psc_of[i]) % NSTEP;
                bnd   = ((k + 1) % (psc_of[i] * NSTEP)) == 0;
                old_p = m_pend[i];
                for (int c = 0; c < 3; c++) begin
                    e_pwm[i][c] = int'((phase < m_act[i][c]) ^ al_of[i]);
                end
                e_ps[i] = int'(bnd);
                if (bnd && old_p) begin
                    for (int c = 0; c < 3; c++) m_act[i][c] = m_sh[i][c];
                    m_pend[i] = 1'b0;
                end
                if (v) begin
                    if (old_p && !bnd && m_drop[i] < 255) m_drop[i]++;
                    for (int c = 0; c < 3; c++) m_sh[i][c] = m_in[c];
                    m_pend[i] = 1'b1;
                end
            end
            k++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (k=%0d, t=%0t)", name, got, exp, k, $time);
    endtask

    // Every cycle: all outputs of both instances against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("pwm_r0", int'(pwm_r0), e_pwm[0][0]);
            chk("pwm_g0", int'(pwm_g0), e_pwm[0][1]);
            chk("pwm_b0", int'(pwm_b0), e_pwm[0][2]);
            chk("period_start0", int'(ps0), e_ps[0]);
            chk("drop_count0", int'(drop0), m_drop[0]);
            chk("pwm_r1", int'(pwm_r1), e_pwm[1][0]);
            chk("pwm_g1", int'(pwm_g1), e_pwm[1][1]);
            chk("pwm_b1", int'(pwm_b1), e_pwm[1][2]);
            chk("period_start1", int'(ps1), e_ps[1]);
            chk("drop_count1", int'(drop1), m_drop[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r_in, input int g_in, input int b_in);
        v  = 1'b1;
        rr = W'(r_in);
        gg = W'(g_in);
        bb = W'(b_in);
        step();
        v  = 1'b0;
    endtask

    task automatic wait_phase(input int per, input int target);
        int guard;
        guard = 0;
        step();
        while ((k % per) != target && guard < 4 * per) begin
            step();
            guard++;
        end
        if ((k % per) != target) chk("wait_phase_timeout", k % per, target);
    endtask

    function automatic int pin(input int inst, input int ch);
        if (inst == 0) return (ch == 0) ? int'(pwm_r0) : (ch == 1) ? int'(pwm_g0) : int'(pwm_b0);
        return (ch == 0) ? int'(pwm_r1) : (ch == 1) ? int'(pwm_g1) : int'(pwm_b1);
    endfunction

    // High cycles per channel over one full period, starting the cycle after period_start.
    task automatic measure(input int inst, output int h_r, output int h_g, output int h_b);
        int per;
        per = psc_of[inst] * NSTEP;
        wait_phase(per, 1);
        h_r = 0;
        h_g = 0;
        h_b = 0;
        repeat (per) begin
            @(negedge clk);
            h_r += pin(inst, 0);
            h_g += pin(inst, 1);
            h_b += pin(inst, 2);
        end
    endtask

    task automatic find_period_starts(input int ncyc, output int first_ps, output int second_ps);
        first_ps  = -1;
        second_ps = -1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #2;
            if (ps0) begin
                if (first_ps < 0) first_ps = c;
                else if (second_ps < 0) second_ps = c;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int fps, sps, hr, hg, hb;

        // Reset held 5 cycles, then idle run.
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_pwm_r0", int'(pwm_r0), 0);
        chk("reset_pwm_r1_active_low", int'(pwm_r1), 1);
        chk("reset_drop0", int'(drop0), 0);
        chk("reset_period_start0", int'(ps0), 0);
        rst = 1'b0;
        find_period_starts(600, fps, sps);
        chk("first_period_start_cycle", fps, 256);
        chk("second_period_start_cycle", sps, 512);
        chk("idle_drop0", int'(drop0), 0);

        // Mid-period sample: held back until the next boundary.
        wait_phase(NSTEP, 100);
        send(64, 128, 255);
        hb = 0;
        repeat (100) begin
            @(negedge clk);
            hb += int'(pwm_b0);
        end
        chk("pre_boundary_b_high", hb, 0);
        measure(0, hr, hg, hb);
        chk("mid_r_high", hr, 64);
        chk("mid_g_high", hg, 128);
        chk("mid_b_high", hb, 255);
        measure(0, hr, hg, hb);
        chk("repeat_b_high", hb, 255);
        chk("mid_drop0", int'(drop0), 0);

        // Two samples in one period: the later one wins, one drop.
        wait_phase(NSTEP, 20);
        send(10, 0, 0);
        wait_phase(NSTEP, 60);
        send(200, 0, 0);
        measure(0, hr, hg, hb);
        chk("overwrite_r_high", hr, 200);
        chk("overwrite_drop0", int'(drop0), 1);

        // Sample on the exact wrap edge while another is pending.
        wait_phase(NSTEP, 200);
        send(20, 7, 7);
        wait_phase(NSTEP, 255);
        send(50, 9, 9);
        measure(0, hr, hg, hb);
        chk("collision_first_r_high", hr, 20);
        measure(0, hr, hg, hb);
        chk("collision_second_r_high", hr, 50);
        chk("collision_drop0", int'(drop0), 1);

        // 300 back-to-back random samples: drop counter saturates.
        wait_phase(NSTEP, 10);
        for (int i = 0; i < 300; i++) begin
            v  = 1'b1;
            rr = W'($urandom_range(0, 255));
            gg = W'($urandom_range(0, 255));
            bb = W'($urandom_range(0, 255));
            step();
        end
        v = 1'b0;
        chk("saturate_drop0", int'(drop0), 255);

        // Prescale 4, active-low instance with duty 1.
        wait_phase(NSTEP, 10);
        send(1, 0, 0);
        measure(1, hr, hg, hb);
        chk("p4_r_low_cycles", 1024 - hr, 4);
        chk("p4_g_low_cycles", 1024 - hg, 0);

        // Random samples at random spacing, checked by the model every cycle.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(1, 600)) step();
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        // Reset mid-operation with a pending sample.
        wait_phase(NSTEP, 10);
        send(128, 0, 0);
        measure(0, hr, hg, hb);
        chk("pre_reset_r_high", hr, 128);
        wait_phase(NSTEP, 100);
        send(30, 0, 0);
        wait_phase(NSTEP, 150);
        rst = 1'b1;
        step();
        chk("midreset_pwm_r0", int'(pwm_r0), 0);
        chk("midreset_pwm_r1", int'(pwm_r1), 1);
        chk("midreset_drop0", int'(drop0), 0);
        rst = 1'b0;
        find_period_starts(300, fps, sps);
        chk("post_reset_period_start_cycle", fps, 256);
        measure(0, hr, hg, hb);
        chk("post_reset_pending_lost_r", hr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
